// File: rtl/noc_params.sv
// rtl/noc_params.sv - shared flit types and transmit-port state encoding
package noc_params;

  localparam int FLIT_DATA_W = 16;

  typedef enum logic [1:0] {
    HEAD     = 2'd0,
    BODY     = 2'd1,
    TAIL     = 2'd2,
    HEADTAIL = 2'd3
  } flit_label_t;

  typedef struct packed {
    flit_label_t            label;
    logic [FLIT_DATA_W-1:0] data;
  } flit_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_VC = 2'd1,
    ACTIVE  = 2'd2
  } tx_state_t;

  function automatic logic is_head(input flit_t f);
    return (f.label == HEAD) || (f.label == HEADTAIL);
  endfunction

endpackage

// File: rtl/output_tx_port_fifo.sv
// rtl/output_tx_port_fifo.sv - transmit flit FIFO with wrap-bit pointers
module tx_fifo
  import noc_params::*;
#(
  parameter int BUFFER_SIZE = 4
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  push,
  input  logic  pop,
  input  flit_t data_i,
  output flit_t data_o,
  output logic  full,
  output logic  empty
);

  localparam int AW = $clog2(BUFFER_SIZE);

  flit_t         mem [BUFFER_SIZE];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is write-only on push; no reset needed because empty masks it
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= data_i;
  end

  assign data_o = mem[rd_ptr[AW-1:0]];
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/output_tx_port.sv
// rtl/output_tx_port.sv - inter-router link transmitter with packet framing
module output_tx_port
  import noc_params::*;
#(
  parameter int BUFFER_SIZE = 4
) (
  input  logic  clk,
  input  logic  rst,
  input  flit_t xb_flit_i,
  input  logic  xb_valid_i,
  output logic  ready_o,
  input  logic  on_off_i,
  input  logic  vc_allocatable_i,
  output flit_t data_o,
  output logic  valid_flit_o,
  output logic  error_o
);

  tx_state_t state, state_next;
  flit_t     front;
  logic      full, empty;
  logic      push, pop, send, frame_err, overflow;

  tx_fifo #(.BUFFER_SIZE(BUFFER_SIZE)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (push),
    .pop    (pop),
    .data_i (xb_flit_i),
    .data_o (front),
    .full   (full),
    .empty  (empty)
  );

  assign ready_o  = !full;
  assign push     = xb_valid_i && !full;
  assign overflow = xb_valid_i && full;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Framing decisions: which front flit leaves, whether it is sent or discarded
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    send       = 1'b0;
    frame_err  = 1'b0;
    if (!empty) begin
      unique case (state)
        IDLE, WAIT_VC: begin
          if (is_head(front)) begin
            if (vc_allocatable_i && on_off_i) begin
              pop        = 1'b1;
              send       = 1'b1;
              state_next = (front.label == HEAD) ? ACTIVE : IDLE;
            end else begin
              state_next = WAIT_VC;
            end
          end else begin
            pop        = 1'b1;
            frame_err  = 1'b1;
            state_next = IDLE;
          end
        end
        ACTIVE: begin
          if (is_head(front)) begin
            pop       = 1'b1;
            frame_err = 1'b1;
          end else if (on_off_i) begin
            pop  = 1'b1;
            send = 1'b1;
            if (front.label == TAIL) state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Link output registers; data_o keeps the last sent flit between sends
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_flit_o <= 1'b0;
      data_o       <= '0;
    end else begin
      valid_flit_o <= send;
      if (send) data_o <= front;
    end
  end

  // Sticky protocol error: framing violation or push into a full FIFO
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                       error_o <= 1'b0;
    else if (frame_err || overflow) error_o <= 1'b1;
  end

endmodule

// File: tb/tb_output_tx_port.sv
// tb/tb_output_tx_port.sv - directed self-checking bench for output_tx_port
module tb_output_tx_port;
  import noc_params::*;

  logic  clk = 1'b0;
  logic  rst;
  flit_t xb_flit_i;
  logic  xb_valid_i;
  logic  ready_o;
  logic  on_off_i;
  logic  vc_allocatable_i;
  flit_t data_o;
  logic  valid_flit_o;
  logic  error_o;

  int errors = 0;
  int checks = 0;

  output_tx_port #(.BUFFER_SIZE(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .xb_flit_i        (xb_flit_i),
    .xb_valid_i       (xb_valid_i),
    .ready_o          (ready_o),
    .on_off_i         (on_off_i),
    .vc_allocatable_i (vc_allocatable_i),
    .data_o           (data_o),
    .valid_flit_o     (valid_flit_o),
    .error_o          (error_o)
  );

  always #5 clk = ~clk;

  function automatic flit_t mk(input flit_label_t l, input logic [15:0] d);
    flit_t f;
    f.label = l;
    f.data  = d;
    return f;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_flit(input flit_t f);
    xb_flit_i  = f;
    xb_valid_i = 1'b1;
  endtask

  initial begin
    rst              = 1'b0;
    xb_valid_i       = 1'b1;
    xb_flit_i        = mk(HEAD, 16'h00AA);
    on_off_i         = 1'b1;
    vc_allocatable_i = 1'b1;

    // Reset held with a valid flit offered
    tick(); tick();
    check("rst_valid", 32'(valid_flit_o), 32'd0);
    check("rst_ready", 32'(ready_o), 32'd1);
    check("rst_error", 32'(error_o), 32'd0);
    check("rst_data",  32'(data_o), 32'd0);
    xb_valid_i = 1'b0;
    rst = 1'b1;
    tick(); tick(); tick();
    check("post_rst_valid", 32'(valid_flit_o), 32'd0);
    check("post_rst_ready", 32'(ready_o), 32'd1);
    check("post_rst_state", 32'(dut.state), 32'(IDLE));

    // 3-flit packet on consecutive cycles
    push_flit(mk(HEAD, 16'h1001));
    tick();
    check("pkt_n1_valid", 32'(valid_flit_o), 32'd0);
    push_flit(mk(BODY, 16'h1002));
    tick();
    check("pkt_n2_valid", 32'(valid_flit_o), 32'd1);
    check("pkt_n2_data",  32'(data_o), 32'(mk(HEAD, 16'h1001)));
    push_flit(mk(TAIL, 16'h1003));
    tick();
    check("pkt_n3_valid", 32'(valid_flit_o), 32'd1);
    check("pkt_n3_data",  32'(data_o), 32'(mk(BODY, 16'h1002)));
    xb_valid_i = 1'b0;
    tick();
    check("pkt_n4_valid", 32'(valid_flit_o), 32'd1);
    check("pkt_n4_data",  32'(data_o), 32'(mk(TAIL, 16'h1003)));
    tick();
    check("pkt_n5_valid", 32'(valid_flit_o), 32'd0);
    check("pkt_n5_hold",  32'(data_o), 32'(mk(TAIL, 16'h1003)));
    check("pkt_state",    32'(dut.state), 32'(IDLE));

    // HEADTAIL waits for vc_allocatable
    vc_allocatable_i = 1'b0;
    push_flit(mk(HEADTAIL, 16'h2001));
    tick();
    xb_valid_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("vcw_valid", 32'(valid_flit_o), 32'd0);
    end
    check("vcw_state", 32'(dut.state), 32'(WAIT_VC));
    vc_allocatable_i = 1'b1;
    tick();
    check("vcw_out_valid", 32'(valid_flit_o), 32'd1);
    check("vcw_out_data",  32'(data_o), 32'(mk(HEADTAIL, 16'h2001)));
    check("vcw_out_state", 32'(dut.state), 32'(IDLE));
    tick();

    // Backpressure mid-packet filling the FIFO
    push_flit(mk(HEAD, 16'h3000));
    tick();
    push_flit(mk(BODY, 16'h3001));
    tick();
    check("bp_head_valid", 32'(valid_flit_o), 32'd1);
    check("bp_head_data",  32'(data_o), 32'(mk(HEAD, 16'h3000)));
    on_off_i = 1'b0;
    push_flit(mk(BODY, 16'h3002));
    tick();
    check("bp_off1_valid", 32'(valid_flit_o), 32'd0);
    check("bp_off1_hold",  32'(data_o), 32'(mk(HEAD, 16'h3000)));
    push_flit(mk(BODY, 16'h3003));
    tick();
    check("bp_off2_valid", 32'(valid_flit_o), 32'd0);
    push_flit(mk(TAIL, 16'h3004));
    tick();
    xb_valid_i = 1'b0;
    check("bp_off3_valid", 32'(valid_flit_o), 32'd0);
    check("bp_full_ready", 32'(ready_o), 32'd0);
    on_off_i = 1'b1;
    #1;
    check("bp_pop_ready", 32'(ready_o), 32'd0);
    tick();
    check("bp_r1_valid", 32'(valid_flit_o), 32'd1);
    check("bp_r1_data",  32'(data_o), 32'(mk(BODY, 16'h3001)));
    check("bp_r1_ready", 32'(ready_o), 32'd1);
    tick();
    check("bp_r2_valid", 32'(valid_flit_o), 32'd1);
    check("bp_r2_data",  32'(data_o), 32'(mk(BODY, 16'h3002)));
    tick();
    check("bp_r3_valid", 32'(valid_flit_o), 32'd1);
    check("bp_r3_data",  32'(data_o), 32'(mk(BODY, 16'h3003)));
    tick();
    check("bp_r4_valid", 32'(valid_flit_o), 32'd1);
    check("bp_r4_data",  32'(data_o), 32'(mk(TAIL, 16'h3004)));
    tick();
    check("bp_end_valid", 32'(valid_flit_o), 32'd0);
    check("bp_end_state", 32'(dut.state), 32'(IDLE));
    check("bp_end_error", 32'(error_o), 32'd0);

    // Stray BODY while IDLE is discarded and flagged
    push_flit(mk(BODY, 16'h4001));
    tick();
    xb_valid_i = 1'b0;
    check("fe_n1_valid", 32'(valid_flit_o), 32'd0);
    tick();
    check("fe_n2_valid", 32'(valid_flit_o), 32'd0);
    check("fe_n2_error", 32'(error_o), 32'd1);
    push_flit(mk(HEADTAIL, 16'h4002));
    tick();
    xb_valid_i = 1'b0;
    check("fe_n3_valid", 32'(valid_flit_o), 32'd0);
    tick();
    check("fe_ht_valid", 32'(valid_flit_o), 32'd1);
    check("fe_ht_data",  32'(data_o), 32'(mk(HEADTAIL, 16'h4002)));
    check("fe_sticky",   32'(error_o), 32'd1);

    // Reset clears the sticky error
    rst = 1'b0;
    #1;
    check("rst2_error", 32'(error_o), 32'd0);
    check("rst2_valid", 32'(valid_flit_o), 32'd0);
    tick();
    rst = 1'b1;
    tick();

    // Overflow while full and off: flit dropped, contents intact
    on_off_i = 1'b0;
    push_flit(mk(HEAD, 16'h5000)); tick();
    push_flit(mk(BODY, 16'h5001)); tick();
    push_flit(mk(BODY, 16'h5002)); tick();
    push_flit(mk(TAIL, 16'h5003)); tick();
    check("ov_full_ready", 32'(ready_o), 32'd0);
    check("ov_pre_error",  32'(error_o), 32'd0);
    push_flit(mk(BODY, 16'h5099)); tick();
    xb_valid_i = 1'b0;
    check("ov_error",     32'(error_o), 32'd1);
    check("ov_no_send",   32'(valid_flit_o), 32'd0);
    on_off_i = 1'b1;
    tick();
    check("ov_d1_valid", 32'(valid_flit_o), 32'd1);
    check("ov_d1_data",  32'(data_o), 32'(mk(HEAD, 16'h5000)));
    tick();
    check("ov_d2_data",  32'(data_o), 32'(mk(BODY, 16'h5001)));
    tick();
    check("ov_d3_data",  32'(data_o), 32'(mk(BODY, 16'h5002)));
    tick();
    check("ov_d4_valid", 32'(valid_flit_o), 32'd1);
    check("ov_d4_data",  32'(data_o), 32'(mk(TAIL, 16'h5003)));
    tick();
    check("ov_end_valid", 32'(valid_flit_o), 32'd0);
    check("ov_end_ready", 32'(ready_o), 32'd1);
    check("ov_end_state", 32'(dut.state), 32'(IDLE));
    check("ov_end_error", 32'(error_o), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/output_tx_port.md
Name: output_tx_port

Overview:
- Transmit end of the inter-router link for one output direction.
- Accepts flits from the crossbar for that direction and buffers them.
- Drives valid_flit/data into the downstream router's input port.
- Obeys the downstream on/off backpressure and vc-allocatable indications.
- Enforces packet framing: a head may start only when downstream is allocatable; body and tail flits follow.

Parameters:
- BUFFER_SIZE, 4, depth of the transmit FIFO in flits (power of 2, ≥2)

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-low reset
- xb_flit_i  input  flit_t  flit from crossbar
- xb_valid_i  input  1  xb_flit_i valid this cycle
- ready_o  output  1  FIFO can accept a flit this cycle, to switch allocator
- on_off_i  input  1  downstream input port on_off (1 = may send)
- vc_allocatable_i  input  1  downstream can start a new packet
- data_o  output  flit_t  flit to downstream data_i
- valid_flit_o  output  1  data_o valid, to downstream valid_flit_i
- error_o  output  1  sticky protocol-error flag

Behaviour:
- Reset (rst=0, async):
  - FIFO empty; state=IDLE.
  - valid_flit_o=0, data_o='0, ready_o=1 after reset, error_o=0.
- Push:
  - Occurs when xb_valid_i && ready_o.
  - ready_o = !full; it is not asserted on a full-and-popping cycle.
  - xb_valid_i while full: flit dropped, error_o set.
- Front flit: head of FIFO when not empty. Its label (HEAD/BODY/TAIL/HEADTAIL) comes from flit_t.
- Send condition evaluated combinationally each cycle; a pop loads the data_o/valid_flit_o registers.
- Latency: push at cycle N, earliest valid_flit_o at cycle N+2. Throughput 1 flit/cycle.
- valid_flit_o=0 in any cycle with no pop; data_o holds its last value.
- FSM states: IDLE, WAIT_VC, ACTIVE.
  - IDLE, front=HEAD/HEADTAIL:
    - if vc_allocatable_i && on_off_i: pop.
    - HEAD goes to ACTIVE; HEADTAIL stays IDLE.
    - else go to WAIT_VC, no pop.
  - IDLE, front=BODY/TAIL: pop and discard (valid_flit_o=0), error_o set, stay IDLE.
  - WAIT_VC: when vc_allocatable_i && on_off_i, pop head; next state as in IDLE. Otherwise hold.
  - ACTIVE, front=BODY: pop when on_off_i; stay ACTIVE.
  - ACTIVE, front=TAIL: pop when on_off_i; go to IDLE.
  - ACTIVE, front=HEAD/HEADTAIL: discard, error_o set, stay ACTIVE.
  - ACTIVE with FIFO empty: hold, no timeout.
- vc_allocatable_i is ignored for BODY/TAIL. on_off_i gates every send. The downstream off threshold covers the one-flight flit.
- Simultaneous push and pop: both occur and occupancy is unchanged. Push into an empty FIFO is not visible at the front until the next cycle (no bypass).
- Pointer wrap: read and write pointers are log2(BUFFER_SIZE)+1 bits. Full when MSBs differ and LSBs are equal.
- error_o clears only on reset.
- Reset mid-packet: all state discarded; the downstream side is reset together.

Decomposition:
- noc_params holds:
  - flit_t and flit_label_t (existing)
  - new enum tx_state_t {IDLE, WAIT_VC, ACTIVE}
- Sub-module tx_fifo (parameter BUFFER_SIZE, flit_t storage):
  - ports: push, pop, data_i, data_o, full, empty
  - owns the pointers
- The FSM and output registers stay in output_tx_port.

Test Plan:
- Reset: hold rst=0 with xb_valid_i=1 → valid_flit_o=0, ready_o=1, error_o=0. Release rst → FIFO empty and no output, because the flit was not pushed during reset.
- 3-flit packet: HEAD, BODY, TAIL on consecutive cycles from N, with on_off_i=1 and vc_allocatable_i=1 → valid_flit_o=1 at N+2, N+3, N+4, in order. FSM returns to IDLE.
- VC wait: push a HEADTAIL with vc_allocatable_i=0 for 5 cycles → no output, state=WAIT_VC. Raise vc_allocatable_i → flit appears 1 cycle later and state=IDLE.
- Backpressure: mid-packet, drop on_off_i for 3 cycles while pushing 4 flits (BUFFER_SIZE=4) → ready_o=0 when full, no sends while off. On resume: 4 sends back-to-back, no loss, error_o=0.
- Framing error: push a BODY while IDLE → discarded, valid_flit_o stays 0, error_o=1 and stays 1. A following HEADTAIL is transmitted normally.
- Overflow: force xb_valid_i=1 while full and on_off_i=0 → error_o=1. FIFO contents are unchanged and drain correctly once on_off_i=1.
